// File: rtl/pmod_ad1_reader.sv
//==============================================================================
// Module   : pmod_ad1_reader
// Desc     : Capture engine for the dual-channel PmodAD1 (2x AD7476A, shared
//            nCS/sclk, separate sdata). Define PMOD_AD1_FREERUN_EN for
//            continuous conversions after the first start.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pmod_ad1_reader #(
  parameter int CLK_DIV      = 2,
  parameter int FRAME_BITS   = 16,
  parameter int DATA_BITS    = 12,
  parameter int QUIET_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sdata0,
  input  logic                 sdata1,
  output logic                 sclk,
  output logic                 nCS,
  output logic [DATA_BITS-1:0] data0,
  output logic [DATA_BITS-1:0] data1,
  output logic                 valid,
  output logic                 busy
);

  localparam int c_DIV_W   = $clog2(CLK_DIV + 1);
  localparam int c_BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int c_QUIET_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  localparam logic [c_DIV_W-1:0]   c_DIV_SETUP  = c_DIV_W'(CLK_DIV);
  localparam logic [c_DIV_W-1:0]   c_DIV_HALF   = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0]   c_BIT_LAST   = c_BIT_W'(FRAME_BITS - 1);
  localparam logic [c_QUIET_W-1:0] c_QUIET_LAST = c_QUIET_W'(QUIET_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CS_SETUP = 2'd1,
    S_SHIFT    = 2'd2,
    S_QUIET    = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_DIV_W-1:0]    r_div;
  logic [c_BIT_W-1:0]    r_bit_cnt;
  logic [c_QUIET_W-1:0]  r_quiet_cnt;
  logic [DATA_BITS-1:0]  r_shift0;
  logic [DATA_BITS-1:0]  r_shift1;
  logic [DATA_BITS-1:0]  r_data0;
  logic [DATA_BITS-1:0]  r_data1;
  logic                  r_sclk;
  logic                  r_ncs;
  logic                  r_valid;
  logic                  r_busy;

  logic                  w_half_done;

  assign w_half_done = (r_div == c_DIV_HALF);

  // Shift registers are only DATA_BITS wide: the leading frame bits simply
  // fall off the top, so the low DATA_BITS of the frame remain at the end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit_cnt   <= '0;
      r_quiet_cnt <= '0;
      r_shift0    <= '0;
      r_shift1    <= '0;
      r_data0     <= '0;
      r_data1     <= '0;
      r_sclk      <= 1'b1;
      r_ncs       <= 1'b1;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ncs  <= 1'b1;
          r_sclk <= 1'b1;
          if (start) begin
            r_state <= S_CS_SETUP;
            r_ncs   <= 1'b0;
            r_busy  <= 1'b1;
            r_div   <= '0;
          end
        end

        // Counts 0..CLK_DIV so nCS leads the first sclk fall by one extra cycle.
        S_CS_SETUP: begin
          if (r_div == c_DIV_SETUP) begin
            r_state <= S_SHIFT;
            r_div   <= '0;
            r_sclk  <= 1'b0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        // r_bit_cnt indexes the current sclk period; it advances on the fall
        // that opens the next period so it never has to hold FRAME_BITS.
        S_SHIFT: begin
          if (!w_half_done) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk   <= 1'b1;
              r_shift0 <= {r_shift0[DATA_BITS-2:0], sdata0};
              r_shift1 <= {r_shift1[DATA_BITS-2:0], sdata1};
            end else if (r_bit_cnt == c_BIT_LAST) begin
              r_state     <= S_QUIET;
              r_ncs       <= 1'b1;
              r_bit_cnt   <= '0;
              r_quiet_cnt <= '0;
              r_data0     <= r_shift0;
              r_data1     <= r_shift1;
              r_valid     <= 1'b1;
            end else begin
              r_sclk    <= 1'b0;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        S_QUIET: begin
          r_ncs  <= 1'b1;
          r_sclk <= 1'b1;
          if (r_quiet_cnt == c_QUIET_LAST) begin
            r_quiet_cnt <= '0;
`ifdef PMOD_AD1_FREERUN_EN
            r_state <= S_CS_SETUP;
            r_ncs   <= 1'b0;
            r_div   <= '0;
`else
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
`endif
          end else begin
            r_quiet_cnt <= r_quiet_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ncs   <= 1'b1;
          r_sclk  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sclk  = r_sclk;
  assign nCS   = r_ncs;
  assign data0 = r_data0;
  assign data1 = r_data1;
  assign valid = r_valid;
  assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pmod_ad1_reader.sv
//==============================================================================
// Module   : tb_pmod_ad1_reader
// Desc     : Scoreboard bench for pmod_ad1_reader with a two-channel ADC model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pmod_ad1_reader;

  localparam int CLK_DIV       = 2;
  localparam int FRAME_BITS    = 16;
  localparam int DATA_BITS     = 12;
  localparam int QUIET_CYCLES  = 4;
  localparam int c_LATENCY     = 1 + CLK_DIV * (1 + 2 * FRAME_BITS);
  localparam int c_PERIOD_HELD = c_LATENCY + QUIET_CYCLES + 1;
  localparam int c_PERIOD_FREE = c_LATENCY + QUIET_CYCLES;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic                 sdata0 = 1'b0;
  logic                 sdata1 = 1'b0;
  logic                 sclk;
  logic                 nCS;
  logic [DATA_BITS-1:0] data0;
  logic [DATA_BITS-1:0] data1;
  logic                 valid;
  logic                 busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  pmod_ad1_reader #(
    .CLK_DIV     (CLK_DIV),
    .FRAME_BITS  (FRAME_BITS),
    .DATA_BITS   (DATA_BITS),
    .QUIET_CYCLES(QUIET_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sdata0(sdata0),
    .sdata1(sdata1),
    .sclk  (sclk),
    .nCS   (nCS),
    .data0 (data0),
    .data1 (data1),
    .valid (valid),
    .busy  (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: presents the next frame bit (MSB first) on each sclk fall.
  logic [15:0] frame0 = 16'h0000;
  logic [15:0] frame1 = 16'h0000;
  int          bit_idx = 16;
  int          sclk_falls = 0;

  always @(negedge nCS) begin
    bit_idx    = 16;
    sclk_falls = 0;
    sdata0     = 1'b0;
    sdata1     = 1'b0;
  end

  always @(negedge sclk) begin
    if (nCS === 1'b0) begin
      sclk_falls++;
      if (bit_idx > 0) bit_idx--;
      sdata0 = frame0[bit_idx];
      sdata1 = frame1[bit_idx];
    end
  end

  // Scoreboard and nCS monitor
  logic [2*DATA_BITS-1:0] exp_q[$];
  int                     valid_times[$];
  int                     valid_cnt = 0;
  int                     ncs_windows = 0;
  int                     hi_run = 0;
  int                     last_gap = 0;
  logic                   prev_ncs = 1'b1;

  always @(negedge clk) begin
    logic [2*DATA_BITS-1:0] exp_v;
    if (valid === 1'b1) begin
      valid_cnt++;
      valid_times.push_back(cyc);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_valid: got data1=%h data0=%h, want no valid", data1, data0);
      end else begin
        exp_v = exp_q.pop_front();
        if ({data1, data0} !== exp_v) begin
          fails++;
          $display("FAIL sb_data: got %h, want %h", {data1, data0}, exp_v);
        end
      end
    end
    if (nCS === 1'b1) begin
      hi_run++;
    end else if (prev_ncs === 1'b1) begin
      last_gap = hi_run;
      ncs_windows++;
      hi_run = 0;
    end
    prev_ncs = nCS;
  end

  task automatic wait_valid(input int target, input int max_cyc, output bit ok);
    int n;
    n = 0;
    while (valid_cnt < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    ok = (valid_cnt >= target);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({nCS, sclk, valid, busy} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_ctrl: got nCS,sclk,valid,busy=%b, want 1100", {nCS, sclk, valid, busy});
    end
    tests++;
    if (data0 !== 12'h000 || data1 !== 12'h000) begin
      fails++;
      $display("FAIL reset_data: got %h/%h, want 000/000", data0, data1);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if ({nCS, sclk, valid, busy} !== 4'b1100) begin
      fails++;
      $display("FAIL idle_after_reset: got %b, want 1100", {nCS, sclk, valid, busy});
    end
  endtask

  task automatic test_single_frame();
    int t0, base, lat;
    bit ok;
    frame0 = 16'h0A5C;
    frame1 = 16'h0FFF;
    exp_q.push_back({12'hFFF, 12'hA5C});
    base = valid_cnt;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || nCS !== 1'b0) begin
      fails++;
      $display("FAIL single_busy_mid: got busy=%b nCS=%b, want 1/0", busy, nCS);
    end
    tests++;
    if (data0 !== 12'h000 || data1 !== 12'h000) begin
      fails++;
      $display("FAIL single_hold_mid: got %h/%h, want 000/000", data0, data1);
    end
    wait_valid(base + 1, 200, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL single_timeout: got %0d valids, want %0d", valid_cnt - base, 1);
    end else begin
      lat = valid_times[valid_times.size() - 1] - t0;
      tests++;
      if (lat !== c_LATENCY) begin
        fails++;
        $display("FAIL single_latency: got %0d, want %0d", lat, c_LATENCY);
      end
    end
    tests++;
    if (sclk_falls !== FRAME_BITS) begin
      fails++;
      $display("FAIL single_sclk_falls: got %0d, want %0d", sclk_falls, FRAME_BITS);
    end
    repeat (10) @(negedge clk);
    tests++;
    if ({nCS, sclk, busy} !== 3'b110) begin
      fails++;
      $display("FAIL single_idle_after: got nCS,sclk,busy=%b, want 110", {nCS, sclk, busy});
    end
    tests++;
    if (data0 !== 12'hA5C || data1 !== 12'hFFF) begin
      fails++;
      $display("FAIL single_data_held: got %h/%h, want A5C/FFF", data0, data1);
    end
  endtask

  task automatic test_leading_bits();
    int base;
    bit ok;
    frame0 = 16'hF123;
    frame1 = 16'h8ABC;
    exp_q.push_back({12'hABC, 12'h123});
    base = valid_cnt;
    pulse_start();
    wait_valid(base + 1, 200, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL leading_timeout: got %0d valids, want 1", valid_cnt - base);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int base, win;
    bit ok;
    frame0 = 16'h0BEE;
    frame1 = 16'h0C0D;
    exp_q.push_back({12'hC0D, 12'hBEE});
    base = valid_cnt;
    win  = ncs_windows;
    pulse_start();
    repeat (18) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(base + 1, 200, ok);
    repeat (100) @(negedge clk);
    tests++;
    if (valid_cnt - base !== 1) begin
      fails++;
      $display("FAIL busy_valid_count: got %0d, want 1", valid_cnt - base);
    end
    tests++;
    if (ncs_windows - win !== 1) begin
      fails++;
      $display("FAIL busy_ncs_windows: got %0d, want 1", ncs_windows - win);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, n;
    base = valid_cnt;
    frame0 = 16'h0555;
    frame1 = 16'h0AAA;
    pulse_start();
    n = 0;
    while (sclk_falls < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sclk_falls < 8) begin
      fails++;
      $display("FAIL midrst_reach: got %0d sclk falls, want 8", sclk_falls);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if ({nCS, sclk, valid, busy} !== 4'b1100) begin
      fails++;
      $display("FAIL midrst_ctrl: got nCS,sclk,valid,busy=%b, want 1100", {nCS, sclk, valid, busy});
    end
    tests++;
    if (data0 !== 12'h000 || data1 !== 12'h000) begin
      fails++;
      $display("FAIL midrst_data: got %h/%h, want 000/000", data0, data1);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (120) @(negedge clk);
    tests++;
    if (valid_cnt !== base || nCS !== 1'b1) begin
      fails++;
      $display("FAIL midrst_no_valid: got %0d valids nCS=%b, want 0 valids nCS=1", valid_cnt - base, nCS);
    end
  endtask

  task automatic test_held_start();
    int base, n, d1, d2;
    bit ok;
    frame0 = 16'h0321;
    frame1 = 16'h0FED;
    repeat (3) exp_q.push_back({12'hFED, 12'h321});
    base = valid_cnt;
    @(negedge clk);
    start = 1'b1;
    wait_valid(base + 3, 400, ok);
    start = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL held_timeout: got %0d valids, want 3", valid_cnt - base);
    end else begin
      n  = valid_times.size();
      d1 = valid_times[n - 2] - valid_times[n - 3];
      d2 = valid_times[n - 1] - valid_times[n - 2];
      tests++;
      if (d1 !== c_PERIOD_HELD || d2 !== c_PERIOD_HELD) begin
        fails++;
        $display("FAIL held_period: got %0d,%0d, want %0d", d1, d2, c_PERIOD_HELD);
      end
      tests++;
      if (last_gap !== QUIET_CYCLES + 1) begin
        fails++;
        $display("FAIL held_ncs_gap: got %0d, want %0d", last_gap, QUIET_CYCLES + 1);
      end
    end
    repeat (20) @(negedge clk);
    tests++;
    if (valid_cnt - base !== 3 || busy !== 1'b0) begin
      fails++;
      $display("FAIL held_stop: got %0d valids busy=%b, want 3/0", valid_cnt - base, busy);
    end
  endtask

  task automatic test_freerun();
    int t0, base, n, d1, d2;
    bit ok;
    frame0 = 16'h0246;
    frame1 = 16'h0135;
    repeat (3) exp_q.push_back({12'h135, 12'h246});
    base = valid_cnt;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(base + 1, 200, ok);
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL free_busy_quiet: got %b, want 1", busy);
    end
    pulse_start();
    wait_valid(base + 3, 400, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL free_timeout: got %0d valids, want 3", valid_cnt - base);
    end else begin
      n  = valid_times.size();
      d1 = valid_times[n - 2] - valid_times[n - 3];
      d2 = valid_times[n - 1] - valid_times[n - 2];
      tests++;
      if (valid_times[n - 3] - t0 !== c_LATENCY) begin
        fails++;
        $display("FAIL free_latency: got %0d, want %0d", valid_times[n - 3] - t0, c_LATENCY);
      end
      tests++;
      if (d1 !== c_PERIOD_FREE || d2 !== c_PERIOD_FREE) begin
        fails++;
        $display("FAIL free_period: got %0d,%0d, want %0d", d1, d2, c_PERIOD_FREE);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef PMOD_AD1_FREERUN_EN
    test_freerun();
`else
    test_single_frame();
    test_leading_bits();
    test_start_while_busy();
    test_reset_mid_frame();
    test_held_start();
`endif
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
